// File: rtl/alu_reservation_station_if.sv
// Bundle of the dispatch, CDB-snoop, ALU issue and result handshakes around
// the arithmetic reservation station.
interface alu_reservation_station_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 64
);
    logic              disp_valid;
    logic              disp_ready;
    logic [4:0]        disp_op;
    logic [5:0]        disp_hw;
    logic [TAG_W-1:0]  disp_dst_tag;
    logic              disp_a_rdy;
    logic              disp_b_rdy;
    logic [DATA_W-1:0] disp_a_val;
    logic [DATA_W-1:0] disp_b_val;
    logic [TAG_W-1:0]  disp_a_tag;
    logic [TAG_W-1:0]  disp_b_tag;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_val;

    logic              alu_start;
    logic [4:0]        alu_op;
    logic [DATA_W-1:0] alu_vala;
    logic [DATA_W-1:0] alu_valb;
    logic [5:0]        alu_valhw;
    logic              alu_done;
    logic [DATA_W-1:0] alu_res;

    logic              res_valid;
    logic [TAG_W-1:0]  res_tag;
    logic [DATA_W-1:0] res_val;
    logic              res_ready;

    modport slave (
        input  disp_valid, disp_op, disp_hw, disp_dst_tag,
               disp_a_rdy, disp_b_rdy, disp_a_val, disp_b_val, disp_a_tag, disp_b_tag,
               cdb_valid, cdb_tag, cdb_val, alu_done, alu_res, res_ready,
        output disp_ready, alu_start, alu_op, alu_vala, alu_valb, alu_valhw,
               res_valid, res_tag, res_val
    );

    modport master (
        output disp_valid, disp_op, disp_hw, disp_dst_tag,
               disp_a_rdy, disp_b_rdy, disp_a_val, disp_b_val, disp_a_tag, disp_b_tag,
               cdb_valid, cdb_tag, cdb_val, alu_done, alu_res, res_ready,
        input  disp_ready, alu_start, alu_op, alu_vala, alu_valb, alu_valhw,
               res_valid, res_tag, res_val
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Tomasulo reservation station feeding the arithmetic execute unit: buffers
// dispatched ops, snoops the CDB, issues one ready op at a time, holds the result.
module alu_reservation_station #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4,
    parameter int DATA_W      = 64
) (
    input  logic clk,
    input  logic rst,
    alu_reservation_station_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {IDLE, BUSY, OUT} state_t;

    state_t            state_reg;
    logic [NUM_ENTRIES-1:0] valid_reg;
    logic [NUM_ENTRIES-1:0] a_rdy_reg;
    logic [NUM_ENTRIES-1:0] b_rdy_reg;
    logic [4:0]        op_reg    [NUM_ENTRIES];
    logic [5:0]        hw_reg    [NUM_ENTRIES];
    logic [TAG_W-1:0]  dst_reg   [NUM_ENTRIES];
    logic [DATA_W-1:0] a_val_reg [NUM_ENTRIES];
    logic [DATA_W-1:0] b_val_reg [NUM_ENTRIES];
    logic [TAG_W-1:0]  a_tag_reg [NUM_ENTRIES];
    logic [TAG_W-1:0]  b_tag_reg [NUM_ENTRIES];

    logic              alu_start_reg;
    logic [4:0]        alu_op_reg;
    logic [DATA_W-1:0] alu_vala_reg;
    logic [DATA_W-1:0] alu_valb_reg;
    logic [5:0]        alu_valhw_reg;
    logic [TAG_W-1:0]  iss_tag_reg;
    logic              res_valid_reg;
    logic [TAG_W-1:0]  res_tag_reg;
    logic [DATA_W-1:0] res_val_reg;

    logic [NUM_ENTRIES-1:0] ready_vec;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  issue_idx;
    logic              any_ready;
    logic              disp_fire;
    logic              issue_fire;
    logic              disp_a_hit;
    logic              disp_b_hit;

    // Occupancy is taken from registers only, so a slot freed by this
    // cycle's issue becomes visible to dispatch one cycle later.
    assign bus.disp_ready = ~(&valid_reg);
    assign disp_fire      = bus.disp_valid && bus.disp_ready;
    assign any_ready      = |ready_vec;
    assign issue_fire     = (state_reg == IDLE) && any_ready;

    assign disp_a_hit = !bus.disp_a_rdy && bus.cdb_valid && (bus.cdb_tag == bus.disp_a_tag);
    assign disp_b_hit = !bus.disp_b_rdy && bus.cdb_valid && (bus.cdb_tag == bus.disp_b_tag);

    // Descending scans so the lowest index wins.
    always_comb begin
        free_idx  = '0;
        issue_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_reg[i]) free_idx = IDX_W'(i);
            if (ready_vec[i])  issue_idx = IDX_W'(i);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign ready_vec[gi] = valid_reg[gi] && a_rdy_reg[gi] && b_rdy_reg[gi];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg[gi] <= 1'b0;
                    a_rdy_reg[gi] <= 1'b0;
                    b_rdy_reg[gi] <= 1'b0;
                    op_reg[gi]    <= '0;
                    hw_reg[gi]    <= '0;
                    dst_reg[gi]   <= '0;
                    a_val_reg[gi] <= '0;
                    b_val_reg[gi] <= '0;
                    a_tag_reg[gi] <= '0;
                    b_tag_reg[gi] <= '0;
                end else if (issue_fire && issue_idx == IDX_W'(gi)) begin
                    valid_reg[gi] <= 1'b0;
                end else if (disp_fire && free_idx == IDX_W'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                    op_reg[gi]    <= bus.disp_op;
                    hw_reg[gi]    <= bus.disp_hw;
                    dst_reg[gi]   <= bus.disp_dst_tag;
                    a_tag_reg[gi] <= bus.disp_a_tag;
                    b_tag_reg[gi] <= bus.disp_b_tag;
                    a_rdy_reg[gi] <= bus.disp_a_rdy || disp_a_hit;
                    b_rdy_reg[gi] <= bus.disp_b_rdy || disp_b_hit;
                    a_val_reg[gi] <= disp_a_hit ? bus.cdb_val : bus.disp_a_val;
                    b_val_reg[gi] <= disp_b_hit ? bus.cdb_val : bus.disp_b_val;
                end else if (valid_reg[gi]) begin
                    if (!a_rdy_reg[gi] && bus.cdb_valid && bus.cdb_tag == a_tag_reg[gi]) begin
                        a_rdy_reg[gi] <= 1'b1;
                        a_val_reg[gi] <= bus.cdb_val;
                    end
                    if (!b_rdy_reg[gi] && bus.cdb_valid && bus.cdb_tag == b_tag_reg[gi]) begin
                        b_rdy_reg[gi] <= 1'b1;
                        b_val_reg[gi] <= bus.cdb_val;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            alu_start_reg <= 1'b0;
            alu_op_reg    <= '0;
            alu_vala_reg  <= '0;
            alu_valb_reg  <= '0;
            alu_valhw_reg <= '0;
            iss_tag_reg   <= '0;
            res_valid_reg <= 1'b0;
            res_tag_reg   <= '0;
            res_val_reg   <= '0;
        end else begin
            alu_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_ready) begin
                        alu_op_reg    <= op_reg[issue_idx];
                        alu_vala_reg  <= a_val_reg[issue_idx];
                        alu_valb_reg  <= b_val_reg[issue_idx];
                        alu_valhw_reg <= hw_reg[issue_idx];
                        iss_tag_reg   <= dst_reg[issue_idx];
                        alu_start_reg <= 1'b1;
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.alu_done) begin
                        res_val_reg   <= bus.alu_res;
                        res_tag_reg   <= iss_tag_reg;
                        res_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.alu_start = alu_start_reg;
    assign bus.alu_op    = alu_op_reg;
    assign bus.alu_vala  = alu_vala_reg;
    assign bus.alu_valb  = alu_valb_reg;
    assign bus.alu_valhw = alu_valhw_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_tag   = res_tag_reg;
    assign bus.res_val   = res_val_reg;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: dispatch, CDB capture, issue
// ordering, result back-pressure and asynchronous reset.
module tb_alu_reservation_station;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_reservation_station_if #(.TAG_W(4), .DATA_W(64)) bus ();

    alu_reservation_station #(.NUM_ENTRIES(4), .TAG_W(4), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_disp(input logic [4:0] op, input logic [3:0] dst,
                            input logic ardy, input logic [63:0] aval, input logic [3:0] atag,
                            input logic brdy, input logic [63:0] bval, input logic [3:0] btag);
        bus.disp_valid   = 1'b1;
        bus.disp_op      = op;
        bus.disp_hw      = {1'b1, op};
        bus.disp_dst_tag = dst;
        bus.disp_a_rdy   = ardy;
        bus.disp_a_val   = aval;
        bus.disp_a_tag   = atag;
        bus.disp_b_rdy   = brdy;
        bus.disp_b_val   = bval;
        bus.disp_b_tag   = btag;
    endtask

    // Called in the first BUSY cycle after alu_start has dropped.
    task automatic finish_op(input logic [63:0] res, input logic [3:0] tag, input int hold);
        bus.alu_done = 1'b1;
        bus.alu_res  = res;
        tick();
        bus.alu_done = 1'b0;
        if (hold > 0) begin
            bus.alu_done = 1'b1;
            bus.alu_res  = 64'hDEAD_BEEF;
        end
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(bus.res_valid), 64'd1);
            check("hold_tag", 64'(bus.res_tag), 64'(tag));
            check("hold_val", bus.res_val, res);
            check("hold_no_start", 64'(bus.alu_start), 64'd0);
            tick();
        end
        bus.alu_done = 1'b0;
        check("res_valid", 64'(bus.res_valid), 64'd1);
        check("res_tag", 64'(bus.res_tag), 64'(tag));
        check("res_val", bus.res_val, res);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("res_cleared", 64'(bus.res_valid), 64'd0);
        check("no_issue_in_handshake", 64'(bus.alu_start), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_hw = '0; bus.disp_dst_tag = '0;
        bus.disp_a_rdy = 1'b0; bus.disp_b_rdy = 1'b0; bus.disp_a_val = '0; bus.disp_b_val = '0;
        bus.disp_a_tag = '0; bus.disp_b_tag = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_val = '0;
        bus.alu_done = 1'b0; bus.alu_res = '0; bus.res_ready = 1'b0;

        repeat (3) tick();
        check("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        check("rst_alu_start", 64'(bus.alu_start), 64'd0);
        check("rst_alu_op", 64'(bus.alu_op), 64'd0);
        check("rst_vala", bus.alu_vala, 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_res_val", bus.res_val, 64'd0);
        rst = 1'b1;
        tick();

        // Both operands ready at dispatch
        set_disp(5'd0, 4'd3, 1'b1, 64'd1, 4'd0, 1'b1, 64'd1, 4'd0);
        tick();
        bus.disp_valid = 1'b0;
        check("t1_no_early_start", 64'(bus.alu_start), 64'd0);
        tick();
        check("t1_start", 64'(bus.alu_start), 64'd1);
        check("t1_vala", bus.alu_vala, 64'd1);
        check("t1_valb", bus.alu_valb, 64'd1);
        check("t1_op", 64'(bus.alu_op), 64'd0);
        check("t1_hw", 64'(bus.alu_valhw), 64'h20);
        tick();
        check("t1_start_pulse", 64'(bus.alu_start), 64'd0);
        check("t1_vala_stable", bus.alu_vala, 64'd1);
        finish_op(64'd2, 4'd3, 0);
        $display("txn t1 done: checks=%0d errors=%0d", checks, errors);

        // Operand A waits for CDB tag 5
        set_disp(5'd4, 4'd1, 1'b0, 64'd0, 4'd5, 1'b1, 64'd7, 4'd0);
        tick();
        bus.disp_valid = 1'b0;
        tick();
        check("t2_waiting", 64'(bus.alu_start), 64'd0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd5; bus.cdb_val = 64'd10;
        tick();
        bus.cdb_valid = 1'b0;
        check("t2_no_start_at_capture", 64'(bus.alu_start), 64'd0);
        tick();
        check("t2_start", 64'(bus.alu_start), 64'd1);
        check("t2_vala", bus.alu_vala, 64'd10);
        check("t2_valb", bus.alu_valb, 64'd7);
        check("t2_op", 64'(bus.alu_op), 64'd4);
        tick();
        finish_op(64'd17, 4'd1, 0);
        $display("txn t2 done: checks=%0d errors=%0d", checks, errors);

        // Dispatch bypass from same-cycle CDB broadcast
        set_disp(5'd7, 4'd2, 1'b0, 64'd0, 4'd6, 1'b1, 64'd3, 4'd0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd6; bus.cdb_val = 64'h20;
        tick();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        check("t3_no_early_start", 64'(bus.alu_start), 64'd0);
        tick();
        check("t3_start", 64'(bus.alu_start), 64'd1);
        check("t3_vala", bus.alu_vala, 64'h20);
        check("t3_valb", bus.alu_valb, 64'd3);
        tick();
        finish_op(64'h23, 4'd2, 0);
        $display("txn t3 done: checks=%0d errors=%0d", checks, errors);

        // Fill the station, drop an extra dispatch, release all on tag 9
        for (int i = 0; i < 4; i++) begin
            set_disp(5'(i), 4'(8 + i), 1'b0, 64'd0, 4'd9, 1'b1, 64'(i), 4'd0);
            tick();
        end
        bus.disp_valid = 1'b0;
        check("t4_full", 64'(bus.disp_ready), 64'd0);
        set_disp(5'd31, 4'd15, 1'b1, 64'h55, 4'd0, 1'b1, 64'h66, 4'd0);
        tick();
        bus.disp_valid = 1'b0;
        check("t4_still_full", 64'(bus.disp_ready), 64'd0);
        check("t4_no_start", 64'(bus.alu_start), 64'd0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_val = 64'h100;
        tick();
        bus.cdb_valid = 1'b0;
        check("t4_full_before_issue", 64'(bus.disp_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_start", 64'(bus.alu_start), 64'd1);
            check("t4_op_order", 64'(bus.alu_op), 64'(i));
            check("t4_vala", bus.alu_vala, 64'h100);
            check("t4_valb", bus.alu_valb, 64'(i));
            check("t4_ready_after_issue", 64'(bus.disp_ready), 64'd1);
            tick();
            check("t4_start_pulse", 64'(bus.alu_start), 64'd0);
            finish_op(64'h200 + 64'(i), 4'(8 + i), (i == 0) ? 5 : 0);
            $display("txn t4 entry %0d done: checks=%0d errors=%0d", i, checks, errors);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_dropped_not_issued", 64'(bus.alu_start), 64'd0);
        end

        // Asynchronous reset while BUSY, late alu_done ignored
        set_disp(5'd1, 4'd2, 1'b1, 64'd4, 4'd0, 1'b1, 64'd5, 4'd0);
        tick();
        bus.disp_valid = 1'b0;
        tick();
        check("t6_start", 64'(bus.alu_start), 64'd1);
        check("t6_vala", bus.alu_vala, 64'd4);
        #1 rst = 1'b0;
        #1;
        check("t6_async_start", 64'(bus.alu_start), 64'd0);
        check("t6_async_disp_ready", 64'(bus.disp_ready), 64'd1);
        check("t6_async_op", 64'(bus.alu_op), 64'd0);
        check("t6_async_vala", bus.alu_vala, 64'd0);
        check("t6_async_hw", 64'(bus.alu_valhw), 64'd0);
        tick();
        rst = 1'b1;
        bus.alu_done = 1'b1;
        bus.alu_res  = 64'h99;
        tick();
        bus.alu_done = 1'b0;
        check("t6_no_res_valid", 64'(bus.res_valid), 64'd0);
        check("t6_res_val", bus.res_val, 64'd0);
        check("t6_res_tag", 64'(bus.res_tag), 64'd0);
        check("t6_no_start", 64'(bus.alu_start), 64'd0);
        check("t6_disp_ready", 64'(bus.disp_ready), 64'd1);
        tick();
        check("t6_still_no_res", 64'(bus.res_valid), 64'd0);
        check("t6_still_no_start", 64'(bus.alu_start), 64'd0);
        $display("txn t6 done: checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
